// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read channel between the fetch stage (master) and imem (slave).
// A request is held with a stable address until the memory returns ack with rdata.
interface fetch_pc_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              req;
    logic [DATA_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, fills the IF/ID register and
// absorbs ID stalls with a one-entry skid buffer; redirects flush and may drain one stray ack.
module fetch_pc_unit #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [DATA_W-1:0] i_branch_pc,
    input  logic              i_jump,
    input  logic [DATA_W-1:0] i_jump_pc,
    fetch_pc_unit_if.master   imem,
    output logic [DATA_W-1:0] o_instruction_IF_ID,
    output logic [DATA_W-1:0] o_updated_pc_IF_ID,
    output logic              o_valid_IF_ID
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] f_align(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

    state_t            r_state;
    logic [DATA_W-1:0] r_pc;
    logic              r_req;
    logic              r_ifid_vld;
    logic [DATA_W-1:0] r_ifid_instr;
    logic [DATA_W-1:0] r_ifid_pc;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_instr;
    logic [DATA_W-1:0] r_skid_pc;

    logic              w_redirect;
    logic [DATA_W-1:0] w_target;
    logic [DATA_W-1:0] w_pc_inc;
    logic              w_accept;
    logic              w_ifid_free;

    // branch_taken belongs to the older instruction, so it wins over jump
    assign w_redirect  = i_branch_taken | i_jump;
    assign w_target    = f_align(i_branch_taken ? i_branch_pc : i_jump_pc);
    assign w_pc_inc    = r_pc + DATA_W'(4);
    assign w_accept    = (r_state == ST_FETCH) && r_req && imem.ack && !w_redirect;
    assign w_ifid_free = !r_ifid_vld || !i_stall;

    assign imem.req            = r_req;
    assign imem.addr           = r_pc;
    assign o_instruction_IF_ID = r_ifid_instr;
    assign o_updated_pc_IF_ID  = r_ifid_pc;
    assign o_valid_IF_ID       = r_ifid_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= f_align(RESET_PC);
            r_req        <= 1'b0;
            r_ifid_vld   <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_skid_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end

                ST_FETCH: begin
                    if (w_redirect) begin
                        r_pc       <= w_target;
                        r_ifid_vld <= 1'b0;
                        r_skid_vld <= 1'b0;
                        // An unanswered request must still be acked; swallow it in DRAIN
                        if (r_req && !imem.ack) begin
                            r_state <= ST_DRAIN;
                            r_req   <= 1'b0;
                        end else begin
                            r_req   <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_pc <= w_pc_inc;
                        if (w_ifid_free) begin
                            r_ifid_vld   <= 1'b1;
                            r_ifid_instr <= imem.rdata;
                            r_ifid_pc    <= w_pc_inc;
                        end else begin
                            r_skid_vld <= 1'b1;
                            r_req      <= 1'b0;
                        end
                    end else if (r_skid_vld && !i_stall) begin
                        r_ifid_vld   <= 1'b1;
                        r_ifid_instr <= r_skid_instr;
                        r_ifid_pc    <= r_skid_pc;
                        r_skid_vld   <= 1'b0;
                        r_req        <= 1'b1;
                    end else if (!i_stall) begin
                        r_ifid_vld <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem.ack) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Skid payload is only meaningful while r_skid_vld is set, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_accept && !w_ifid_free) begin
            r_skid_instr <= imem.rdata;
            r_skid_pc    <= w_pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, slow memory, stall skid, redirects,
// branch/jump priority, and PC wrap plus reset-in-DRAIN on a second instance.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_pc = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_pc = '0;
    logic [31:0] instr0, upc0;
    logic        vld0;

    logic        rst1 = 1'b1;
    logic        stall1 = 1'b0;
    logic        br1 = 1'b0;
    logic [31:0] br_pc1 = '0;
    logic        jmp1 = 1'b0;
    logic [31:0] jmp_pc1 = '0;
    logic [31:0] instr1, upc1;
    logic        vld1;

    int n_total = 0;
    int n_bad   = 0;

    fetch_pc_unit_if #(.DATA_W(32)) imem0 ();
    fetch_pc_unit_if #(.DATA_W(32)) imem1 ();

    fetch_pc_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk                 (clk),
        .rst                 (rst),
        .i_stall             (stall),
        .i_branch_taken      (br),
        .i_branch_pc         (br_pc),
        .i_jump              (jmp),
        .i_jump_pc           (jmp_pc),
        .imem                (imem0),
        .o_instruction_IF_ID (instr0),
        .o_updated_pc_IF_ID  (upc0),
        .o_valid_IF_ID       (vld0)
    );

    fetch_pc_unit #(.DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk                 (clk),
        .rst                 (rst1),
        .i_stall             (stall1),
        .i_branch_taken      (br1),
        .i_branch_pc         (br_pc1),
        .i_jump              (jmp1),
        .i_jump_pc           (jmp_pc1),
        .imem                (imem1),
        .o_instruction_IF_ID (instr1),
        .o_updated_pc_IF_ID  (upc1),
        .o_valid_IF_ID       (vld1)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        imem0.ack = 1'b0; imem0.rdata = '0;
        imem1.ack = 1'b0; imem1.rdata = '0;
        rst = 1'b1;
        repeat (3) cyc();
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem0.req); end
        n_total++; if (imem0.addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", imem0.addr); end
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", vld0); end
        n_total++; if (instr0 !== 32'h0) begin n_bad++; $display("FAIL rst_instr got=%h exp=0", instr0); end
        n_total++; if (upc0 !== 32'h0) begin n_bad++; $display("FAIL rst_upc got=%h exp=0", upc0); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        // BOOT cycle: an ack here must be ignored
        imem0.ack = 1'b1; imem0.rdata = 32'h0000_0099;
        cyc();
        n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL boot_req got=%b exp=1", imem0.req); end
        n_total++; if (imem0.addr !== 32'h0) begin n_bad++; $display("FAIL boot_addr got=%h exp=0", imem0.addr); end
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL boot_valid got=%b exp=0", vld0); end
        for (int k = 0; k < 3; k++) begin
            imem0.rdata = 32'h1000_0000 + 32'(k * 4);
            cyc();
            n_total++; if (imem0.addr !== 32'((k + 1) * 4)) begin n_bad++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, imem0.addr, 32'((k + 1) * 4)); end
            n_total++; if (upc0 !== 32'((k + 1) * 4)) begin n_bad++; $display("FAIL seq_upc k=%0d got=%h exp=%h", k, upc0, 32'((k + 1) * 4)); end
            n_total++; if (instr0 !== 32'h1000_0000 + 32'(k * 4)) begin n_bad++; $display("FAIL seq_instr k=%0d got=%h", k, instr0); end
            n_total++; if (vld0 !== 1'b1) begin n_bad++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, vld0); end
        end
    endtask

    task automatic test_delayed_ack();
        imem0.ack = 1'b1; imem0.rdata = 32'h1000_000C;
        cyc();
        imem0.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL slow_req i=%0d got=%b exp=1", i, imem0.req); end
            n_total++; if (imem0.addr !== 32'h10) begin n_bad++; $display("FAIL slow_addr i=%0d got=%h exp=10", i, imem0.addr); end
        end
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL slow_bubble got=%b exp=0", vld0); end
        imem0.ack = 1'b1; imem0.rdata = 32'hA5A5_0010;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (vld0 !== 1'b1) begin n_bad++; $display("FAIL slow_valid got=%b exp=1", vld0); end
        n_total++; if (instr0 !== 32'hA5A5_0010) begin n_bad++; $display("FAIL slow_instr got=%h exp=a5a50010", instr0); end
        n_total++; if (upc0 !== 32'h14) begin n_bad++; $display("FAIL slow_upc got=%h exp=14", upc0); end
        n_total++; if (imem0.addr !== 32'h14) begin n_bad++; $display("FAIL slow_next_addr got=%h exp=14", imem0.addr); end
        cyc();
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL slow_single_load got=%b exp=0", vld0); end
        n_total++; if (instr0 !== 32'hA5A5_0010) begin n_bad++; $display("FAIL slow_hold got=%h exp=a5a50010", instr0); end
    endtask

    task automatic test_stall_skid();
        imem0.ack = 1'b1; imem0.rdata = 32'h1111_0014;
        cyc();
        stall = 1'b1; imem0.rdata = 32'hDEAD_BEEF;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL skid_req got=%b exp=0", imem0.req); end
        n_total++; if (instr0 !== 32'h1111_0014) begin n_bad++; $display("FAIL skid_hold_instr got=%h exp=11110014", instr0); end
        n_total++; if (upc0 !== 32'h18) begin n_bad++; $display("FAIL skid_hold_upc got=%h exp=18", upc0); end
        n_total++; if (vld0 !== 1'b1) begin n_bad++; $display("FAIL skid_hold_valid got=%b exp=1", vld0); end
        cyc();
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL skid_req2 got=%b exp=0", imem0.req); end
        stall = 1'b0;
        cyc();
        n_total++; if (instr0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL skid_rel_instr got=%h exp=deadbeef", instr0); end
        n_total++; if (upc0 !== 32'h1C) begin n_bad++; $display("FAIL skid_rel_upc got=%h exp=1c", upc0); end
        n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL skid_rel_req got=%b exp=1", imem0.req); end
        n_total++; if (imem0.addr !== 32'h1C) begin n_bad++; $display("FAIL skid_rel_addr got=%h exp=1c", imem0.addr); end
    endtask

    task automatic test_redirect_drain();
        imem0.ack = 1'b1; imem0.rdata = 32'h1000_001C;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (imem0.addr !== 32'h20) begin n_bad++; $display("FAIL drn_pre_addr got=%h exp=20", imem0.addr); end
        br = 1'b1; br_pc = 32'h0000_0103;
        cyc();
        br = 1'b0;
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL drn_valid got=%b exp=0", vld0); end
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL drn_req got=%b exp=0", imem0.req); end
        cyc();
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL drn_req_wait got=%b exp=0", imem0.req); end
        imem0.ack = 1'b1; imem0.rdata = 32'hBAD0_BAD0;
        cyc();
        n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL drn_resume_req got=%b exp=1", imem0.req); end
        n_total++; if (imem0.addr !== 32'h100) begin n_bad++; $display("FAIL drn_resume_addr got=%h exp=100", imem0.addr); end
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL drn_stray_valid got=%b exp=0", vld0); end
        n_total++; if (instr0 !== 32'h1000_001C) begin n_bad++; $display("FAIL drn_stray_instr got=%h exp=1000001c", instr0); end
        imem0.rdata = 32'h1000_0100;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (upc0 !== 32'h104) begin n_bad++; $display("FAIL drn_target_upc got=%h exp=104", upc0); end
        n_total++; if (instr0 !== 32'h1000_0100) begin n_bad++; $display("FAIL drn_target_instr got=%h exp=10000100", instr0); end
    endtask

    task automatic test_branch_jump_priority();
        stall = 1'b1;
        br = 1'b1; br_pc = 32'h200;
        jmp = 1'b1; jmp_pc = 32'h400;
        imem0.ack = 1'b1; imem0.rdata = 32'h5555_5555;
        cyc();
        br = 1'b0; jmp = 1'b0; stall = 1'b0;
        n_total++; if (imem0.addr !== 32'h200) begin n_bad++; $display("FAIL prio_addr got=%h exp=200", imem0.addr); end
        n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL prio_req got=%b exp=1", imem0.req); end
        n_total++; if (vld0 !== 1'b0) begin n_bad++; $display("FAIL prio_valid got=%b exp=0", vld0); end
        imem0.rdata = 32'h1000_0200;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (upc0 !== 32'h204) begin n_bad++; $display("FAIL prio_upc got=%h exp=204", upc0); end
        n_total++; if (instr0 !== 32'h1000_0200) begin n_bad++; $display("FAIL prio_instr got=%h exp=10000200", instr0); end
        jmp = 1'b1; jmp_pc = 32'h402;
        cyc();
        jmp = 1'b0;
        n_total++; if (imem0.req !== 1'b0) begin n_bad++; $display("FAIL jmp_drn_req got=%b exp=0", imem0.req); end
        imem0.ack = 1'b1; imem0.rdata = 32'hBAD0_0000;
        cyc();
        imem0.ack = 1'b0;
        n_total++; if (imem0.addr !== 32'h400) begin n_bad++; $display("FAIL jmp_addr got=%h exp=400", imem0.addr); end
        n_total++; if (imem0.req !== 1'b1) begin n_bad++; $display("FAIL jmp_req got=%b exp=1", imem0.req); end
    endtask

    task automatic test_wrap_and_reset();
        rst1 = 1'b1;
        repeat (2) cyc();
        n_total++; if (imem1.req !== 1'b0) begin n_bad++; $display("FAIL wrap_rst_req got=%b exp=0", imem1.req); end
        n_total++; if (imem1.addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_rst_addr got=%h exp=fffffffc", imem1.addr); end
        rst1 = 1'b0;
        cyc();
        n_total++; if (imem1.req !== 1'b1) begin n_bad++; $display("FAIL wrap_req got=%b exp=1", imem1.req); end
        imem1.ack = 1'b1; imem1.rdata = 32'hC0DE_0000;
        cyc();
        imem1.ack = 1'b0;
        n_total++; if (upc1 !== 32'h0) begin n_bad++; $display("FAIL wrap_upc got=%h exp=0", upc1); end
        n_total++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got=%b exp=1", vld1); end
        n_total++; if (imem1.addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got=%h exp=0", imem1.addr); end
        n_total++; if (instr1 !== 32'hC0DE_0000) begin n_bad++; $display("FAIL wrap_instr got=%h exp=c0de0000", instr1); end
        br1 = 1'b1; br_pc1 = 32'h40;
        cyc();
        br1 = 1'b0;
        n_total++; if (imem1.req !== 1'b0) begin n_bad++; $display("FAIL wrap_drn_req got=%b exp=0", imem1.req); end
        rst1 = 1'b1;
        cyc();
        n_total++; if (imem1.req !== 1'b0) begin n_bad++; $display("FAIL drn_rst_req got=%b exp=0", imem1.req); end
        n_total++; if (imem1.addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL drn_rst_addr got=%h exp=fffffffc", imem1.addr); end
        n_total++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL drn_rst_valid got=%b exp=0", vld1); end
        n_total++; if (instr1 !== 32'h0) begin n_bad++; $display("FAIL drn_rst_instr got=%h exp=0", instr1); end
        rst1 = 1'b0;
        cyc();
        n_total++; if (imem1.req !== 1'b1) begin n_bad++; $display("FAIL drn_rst_boot_req got=%b exp=1", imem1.req); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_stall_skid();
        test_redirect_drain();
        test_branch_jump_priority();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
